// File: rtl/muldiv_iter_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_iter_pkg
// Shared constants for the iterative multiply/divide unit: operation codes,
// HI/LO read-select values and FSM state encodings.
// -----------------------------------------------------------------------------
package muldiv_iter_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam logic RD_LO = 1'b0;
    localparam logic RD_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the unsigned datapath.
//   multiply : shift-add, {acc,lo} is the partial product, lo holds the
//              unretired multiplier bits (LSB first).
//   divide   : restoring subtract, acc is the partial remainder, lo holds the
//              unretired dividend bits (MSB first) and collects quotient bits.
// Ports:
//   i_is_div      1 = divide step, 0 = multiply step
//   i_acc, i_lo   current accumulator / low register
//   i_opd         multiplicand or divisor (magnitude)
//   o_acc, o_lo   next accumulator / low register
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_is_div,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_lo,
    input  logic [DATA_WIDTH-1:0] i_opd,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_lo
);

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_ge;

    assign w_sum    = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opd} : '0);
    assign w_rem_sh = {i_acc, i_lo[DATA_WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, i_opd});
    // When the subtract is taken the result is below the divisor, so the
    // low DATA_WIDTH bits of the difference are exact.
    assign w_diff   = w_rem_sh[DATA_WIDTH-1:0] - i_opd;

    assign o_acc = i_is_div ? (w_ge ? w_diff : w_rem_sh[DATA_WIDTH-1:0])
                            : w_sum[DATA_WIDTH:1];
    assign o_lo  = i_is_div ? {i_lo[DATA_WIDTH-2:0], w_ge}
                            : {w_sum[0], i_lo[DATA_WIDTH-1:1]};

endmodule

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative HI/LO multiply/divide unit. Signed operations run on magnitudes
// during CALC and are sign-corrected in a single FIX cycle.
// Ports:
//   i_clk, i_arst_n        clock (rising edge), async active-low reset
//   i_start, i_op          operation request and code (accepted in IDLE only)
//   i_data_a, i_data_b     operands (a = multiplicand/dividend/move source)
//   i_kill                 abort any in-flight operation
//   i_rd_sel, o_dout       HI/LO read port (combinational)
//   o_busy                 operation in flight (CALC or FIX)
//   o_done                 one-cycle completion pulse
//   o_div_zero             one-cycle divide-by-zero pulse
// -----------------------------------------------------------------------------
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_kill,
    input  logic                  i_rd_sel,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_zero
);

    localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_hi, r_lo;
    logic [DATA_WIDTH-1:0] r_acc, r_lo_acc, r_opd;
    logic                  r_is_div, r_neg_lo, r_neg_hi;
    logic                  r_done, r_div_zero;

    logic                      w_signed, w_sign_a, w_sign_b;
    logic [DATA_WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [2*DATA_WIDTH-1:0]   w_prod_fix;
    logic [DATA_WIDTH-1:0]     w_fix_hi, w_fix_lo;
    logic [DATA_WIDTH-1:0]     w_acc_chain [0:BITS_PER_CYCLE];
    logic [DATA_WIDTH-1:0]     w_lo_chain  [0:BITS_PER_CYCLE];

    // Operand magnitudes; the most-negative value maps to 2^(W-1), which
    // still fits as an unsigned W-bit number.
    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_sign_a = w_signed & i_data_a[DATA_WIDTH-1];
    assign w_sign_b = w_signed & i_data_b[DATA_WIDTH-1];
    assign w_abs_a  = w_sign_a ? -i_data_a : i_data_a;
    assign w_abs_b  = w_sign_b ? -i_data_b : i_data_b;

    assign w_acc_chain[0] = r_acc;
    assign w_lo_chain[0]  = r_lo_acc;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
            .i_is_div (r_is_div),
            .i_acc    (w_acc_chain[g]),
            .i_lo     (w_lo_chain[g]),
            .i_opd    (r_opd),
            .o_acc    (w_acc_chain[g+1]),
            .o_lo     (w_lo_chain[g+1])
        );
    end

    // Sign correction applied in FIX.
    always_comb begin
        // NOTE: every output gets a default at the top so no path infers a latch.
        w_prod_fix = r_neg_lo ? -{r_acc, r_lo_acc} : {r_acc, r_lo_acc};
        w_fix_hi   = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        w_fix_lo   = w_prod_fix[DATA_WIDTH-1:0];
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? -r_lo_acc : r_lo_acc;
            w_fix_hi = r_neg_hi ? -r_acc    : r_acc;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_lo_acc   <= '0;
            r_opd      <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if (i_kill) begin
                // Kill beats everything, including a same-cycle start.
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            case (i_op)
                                OP_MULT, OP_MULTU: begin
                                    r_acc    <= '0;
                                    r_lo_acc <= w_abs_b;
                                    r_opd    <= w_abs_a;
                                    r_is_div <= 1'b0;
                                    r_neg_lo <= w_sign_a ^ w_sign_b;
                                    r_neg_hi <= 1'b0;
                                    r_cnt    <= CNT_W'(N);
                                    r_state  <= CALC;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (i_data_b == '0) begin
                                        r_div_zero <= 1'b1;
                                    end else begin
                                        r_acc    <= '0;
                                        r_lo_acc <= w_abs_a;
                                        r_opd    <= w_abs_b;
                                        r_is_div <= 1'b1;
                                        r_neg_lo <= w_sign_a ^ w_sign_b;
                                        r_neg_hi <= w_sign_a;
                                        r_cnt    <= CNT_W'(N);
                                        r_state  <= CALC;
                                    end
                                end
                                OP_MTHI: r_hi <= i_data_a;
                                OP_MTLO: r_lo <= i_data_a;
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        r_acc    <= w_acc_chain[BITS_PER_CYCLE];
                        r_lo_acc <= w_lo_chain[BITS_PER_CYCLE];
                        r_cnt    <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) r_state <= FIX;
                    end
                    FIX: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_dout     = (i_rd_sel == RD_HI) ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter
// Directed bench for muldiv_iter: a 1-bit-per-cycle instance (dut) and a
// 2-bits-per-cycle instance (dut2) sharing clock, reset and operand inputs.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         start, start2, kill, rd_sel;
    logic [2:0]   op;
    logic [W-1:0] data_a, data_b;
    logic [W-1:0] dout, dout2;
    logic         busy, done, div_zero;
    logic         busy2, done2, div_zero2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.DATA_WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_op(op),
        .i_data_a(data_a), .i_data_b(data_b), .i_kill(kill), .i_rd_sel(rd_sel),
        .o_dout(dout), .o_busy(busy), .o_done(done), .o_div_zero(div_zero)
    );

    muldiv_iter #(.DATA_WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(start2), .i_op(op),
        .i_data_a(data_a), .i_data_b(data_b), .i_kill(1'b0), .i_rd_sel(rd_sel),
        .o_dout(dout2), .o_busy(busy2), .o_done(done2), .o_div_zero(div_zero2)
    );

    typedef struct {
        op_e         op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; reads HI then LO of the selected instance.
    task automatic read_hilo(input bit which, output logic [W-1:0] hi, output logic [W-1:0] lo);
        rd_sel = RD_HI; #1;
        hi = which ? dout2 : dout;
        rd_sel = RD_LO; #1;
        lo = which ? dout2 : dout;
    endtask

    // Called at a negedge. Returns cycles from the accept edge to the o_done
    // cycle and the number of busy cycles seen before it; leaves the bench at
    // the negedge of the o_done cycle (or at the timeout).
    task automatic run_op(input bit which, input op_e o, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat, output int nbusy);
        op = o; data_a = a; data_b = b;
        if (which) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        op = OP_MTHI; data_a = $urandom; data_b = $urandom;
        lat = 1; nbusy = 0;
        while (!(which ? done2 : done) && lat < 100) begin
            nbusy += int'(which ? busy2 : busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic single(input op_e o, input logic [W-1:0] a);
        op = o; data_a = a; data_b = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t vecs[12];
    int lat, nbusy;
    logic [W-1:0] hi, lo;

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[6]  = '{OP_MULTU, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780};
        vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[10] = '{OP_DIVU,  32'd3,         32'd5,         32'd3,         32'd0};
        vecs[11] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};

        arst_n = 1'b0; start = 1'b0; start2 = 1'b0; kill = 1'b0;
        rd_sel = RD_LO; op = OP_MULT; data_a = '0; data_b = '0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divz", 64'(div_zero), 64'd0);
        read_hilo(1'b0, hi, lo);
        check("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Table: each vector starts in the o_done cycle of the previous one.
        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("v%0d_busy", i), 64'(nbusy), 64'd33);
            read_hilo(1'b0, hi, lo);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
        end
        @(negedge clk);

        // Moves, then divide by zero.
        single(OP_MTHI, 32'h11);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        single(OP_MTLO, 32'h22);
        read_hilo(1'b0, hi, lo);
        check("mt_hilo", {hi, lo}, {32'h11, 32'h22});
        op = OP_DIVU; data_a = 32'd5; data_b = 32'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("dz_pulse", 64'(div_zero), 64'd1);
        nbusy = 0; lat = 0;
        for (int c = 0; c < 40; c++) begin
            nbusy += int'(busy); lat += int'(done);
            @(negedge clk);
            if (c == 0) check("dz_pulse_end", 64'(div_zero), 64'd0);
        end
        check("dz_busy_cycles", 64'(nbusy), 64'd0);
        check("dz_done_cycles", 64'(lat), 64'd0);
        read_hilo(1'b0, hi, lo);
        check("dz_hilo", {hi, lo}, {32'h11, 32'h22});

        // Kill 10 cycles into MULT; reads during CALC return old values.
        op = OP_MULT; data_a = 32'd3; data_b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        read_hilo(1'b0, hi, lo);
        check("calc_read_old", {hi, lo}, {32'h11, 32'h22});
        check("calc_busy", 64'(busy), 64'd1);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            lat += int'(done);
            @(negedge clk);
        end
        check("kill_no_done", 64'(lat), 64'd0);
        read_hilo(1'b0, hi, lo);
        check("kill_hilo", {hi, lo}, {32'h11, 32'h22});
        run_op(1'b0, OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, nbusy);
        check("restart_latency", 64'(lat), 64'd34);
        read_hilo(1'b0, hi, lo);
        check("restart_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Kill and start in the same cycle: start dropped.
        op = OP_MTLO; data_a = 32'hDEAD; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("kill_start_busy", 64'(busy), 64'd0);
        op = OP_DIVU; data_a = 32'd9; data_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_divz", 64'(div_zero), 64'd0);
        read_hilo(1'b0, hi, lo);
        check("kill_start_lo", 64'(lo), 64'hFFFF_FFF1);

        // Reset mid-operation.
        op = OP_MULTU; data_a = 32'd6; data_b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        read_hilo(1'b0, hi, lo);
        check("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            lat += int'(done);
            @(negedge clk);
        end
        check("arst_no_done", 64'(lat), 64'd0);

        // Two bits per cycle, back-to-back in the o_done cycle.
        run_op(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'h2, lat, nbusy);
        check("b2_latency", 64'(lat), 64'd18);
        check("b2_busy", 64'(nbusy), 64'd17);
        read_hilo(1'b1, hi, lo);
        check("b2_result", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
        run_op(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h2, lat, nbusy);
        check("b2_b2b_latency", 64'(lat), 64'd18);
        read_hilo(1'b1, hi, lo);
        check("b2_b2b_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
